// File: rtl/ltl_violation_collector.sv
// Timestamps LTL cluster violations into a show-ahead FIFO (push cycle N -> rpt_valid N+1), keeps hit counters and irq.
// Backpressure: rpt_ready stalls the head entry; when the FIFO is full and there is no pop, new entries are dropped and counted.
module ltl_violation_collector #(
  parameter int NUM_PROPS = 5,
  parameter int SYM_W     = 8,
  parameter int TS_W      = 16,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic [SYM_W-1:0]           symbols,
  input  logic [NUM_PROPS-1:0]       ltl_hits,
  input  logic                       clear,
  output logic                       rpt_valid,
  input  logic                       rpt_ready,
  output logic [TS_W-1:0]            rpt_ts,
  output logic [NUM_PROPS-1:0]       rpt_hits,
  output logic [SYM_W-1:0]           rpt_sym,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic [NUM_PROPS*CNT_W-1:0] hit_cnt,
  output logic                       irq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef struct packed {
    logic [TS_W-1:0]      ts;
    logic [NUM_PROPS-1:0] hits;
    logic [SYM_W-1:0]     sym;
  } entry_t;

  logic [TS_W-1:0]  ts;
  logic [TS_W-1:0]  ts_d;
  logic [SYM_W-1:0] sym_d;
  logic             run_d;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  logic push_req;
  logic push;
  logic full;
  logic pop;
  logic wr_en;
  logic drop;

  // Symbol and timestamp delayed one cycle so they line up with the cluster flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts    <= '0;
      ts_d  <= '0;
      sym_d <= '0;
      run_d <= 1'b0;
    end else if (clear) begin
      ts    <= '0;
      ts_d  <= '0;
      sym_d <= '0;
      run_d <= 1'b0;
    end else begin
      run_d <= run;
      sym_d <= symbols;
      ts_d  <= ts;
      if (run) ts <= ts + TS_W'(1);
    end
  end

  always_comb begin
    push_req = run_d & (|ltl_hits);
    push     = push_req & ~clear;
    full     = (fifo_level == LVL_W'(DEPTH));
    pop      = rpt_valid & rpt_ready;
    // A pop frees the slot the incoming entry needs, so a full FIFO still accepts.
    wr_en    = push & (~full | pop);
    drop     = push & full & ~pop;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
    end else if (clear) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= '{ts: ts_d, hits: ltl_hits, sym: sym_d};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != {CNT_W{1'b1}}) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  // Counters see every captured flag, including those of dropped entries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt <= '0;
    end else if (clear) begin
      hit_cnt <= '0;
    end else if (push) begin
      for (int i = 0; i < NUM_PROPS; i++) begin
        if (ltl_hits[i] && (hit_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}}))
          hit_cnt[i*CNT_W +: CNT_W] <= hit_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end

  assign head      = mem[rd_ptr];
  assign rpt_ts    = head.ts;
  assign rpt_hits  = head.hits;
  assign rpt_sym   = head.sym;
  assign rpt_valid = (fifo_level != '0);
  assign irq       = rpt_valid | overflow;

endmodule
